// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bus for imm_extend_pipe: immediate field in, extended result out.
interface imm_extend_pipe_if #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_neg;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_neg
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_neg
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate extender (sign / zero / sign+shift / upper).
// Optional statistics ports (beat_cnt, sat_seen) under IMM_EXTEND_PIPE_STATS_EN.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_extend_pipe_if.slave   bus
`ifdef IMM_EXTEND_PIPE_STATS_EN
  ,
  output logic [15:0]        beat_cnt,
  output logic               sat_seen
`endif
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_SIGN  = 2'b00;
  localparam logic [1:0] MODE_ZERO  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_UPPER = 2'b11;

  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_data_q,  s1_data_d;
  logic [1:0]       s1_mode_q,  s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] s2_data_q,  s2_data_d;
  logic             s2_neg_q,   s2_neg_d;

  logic             s2_load_c;
  logic             accept_c;
  logic [OUT_W-1:0] ext_sign_c;
  logic [OUT_W-1:0] result_c;

  // Handshake; in_ready is held low while reset is asserted.
  assign s2_load_c    = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = rst_n && (!s1_valid_q || s2_load_c);
  assign accept_c     = bus.in_valid && bus.in_ready;

  // Extension of the S1 immediate, computed on its way into S2.
  always_comb begin
    ext_sign_c = {{PAD_W{s1_data_q[IN_W-1]}}, s1_data_q};
    result_c   = ext_sign_c;
    unique case (s1_mode_q)
      MODE_SIGN:  result_c = ext_sign_c;
      MODE_ZERO:  result_c = OUT_W'(s1_data_q);
      MODE_SHIFT: result_c = ext_sign_c << SHIFT;
      MODE_UPPER: result_c = {s1_data_q, {PAD_W{1'b0}}};
      default:    result_c = ext_sign_c;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_neg_d   = s2_neg_q;

    // S2 either takes the S1 beat or empties once its beat has left.
    if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = result_c;
        s2_neg_d  = result_c[OUT_W-1];
      end
    end

    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_data_d  = bus.in_data;
      s1_mode_d  = bus.in_mode;
    end else if (s2_load_c) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_neg_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_neg_q   <= s2_neg_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_neg   = s2_neg_q;

`ifdef IMM_EXTEND_PIPE_STATS_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic        sat_seen_q, sat_seen_d;
  logic        shift_lost_c;

  // A mode-10 shift overflows when any bit pushed out differs from the new sign.
  always_comb begin
    shift_lost_c = 1'b0;
    for (int unsigned i = OUT_W - SHIFT; i < OUT_W; i++) begin
      if (ext_sign_c[i] != result_c[OUT_W-1]) shift_lost_c = 1'b1;
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    sat_seen_d = sat_seen_q;
    if (s2_valid_q && bus.out_ready && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
    if (s1_valid_q && s2_load_c && (s1_mode_q == MODE_SHIFT) && shift_lost_c) begin
      sat_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      sat_seen_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      sat_seen_q <= sat_seen_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign sat_seen = sat_seen_q;
`endif

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the KGP-RISC datapath. It generalises the fixed-width combinational sign extender with configurable input and output widths and a runtime mode: sign, zero, sign-plus-shift (branch offsets) and upper placement. It adds a 2-stage valid/ready pipeline so it can sit between decode and execute and absorb back-pressure.

Parameters:
IN_W, 12, immediate field width; must satisfy 1 <= IN_W < OUT_W.
OUT_W, 32, extended result width.
SHIFT, 2, left-shift amount for mode 2; must satisfy 0 <= SHIFT < OUT_W.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream presents a beat.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  IN_W  raw immediate field.
in_mode  input  2  00 sign, 01 zero, 10 sign then shift-left by SHIFT, 11 upper.
out_valid  output  1  out_data holds a valid result.
out_ready  input  1  downstream accepts the result this cycle.
out_data  output  OUT_W  extended result.
out_neg  output  1  out_data[OUT_W-1] of the current result.

Behaviour:
- Reset: async assert on rst_n low.
  - s1_valid, s2_valid, out_valid = 0; out_data = 0; out_neg = 0; all stage registers = 0.
  - in_ready is forced 0 while rst_n is low.
  - Operation resumes on the first rising clk edge after deassertion.
- Stage 1 (S1) registers in_data and in_mode. Stage 2 (S2) registers the computed result. out_data and out_valid come directly from S2 flops.
- Handshake:
  - s2_load = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_load.
  - An input beat is accepted when in_valid & in_ready.
  - An output beat transfers when out_valid & out_ready.
- Advance rules, per clk edge:
  - S2 loads the S1 result when s1_valid & s2_load.
  - S2 clears out_valid when it transfers and S1 is empty.
  - S1 loads a beat when it is accepted; otherwise S1 clears when it moves into S2.
- Timing: latency is 2 cycles from acceptance to out_valid with out_ready held high. Throughput is 1 beat per cycle.
- Ordering and stability: strict FIFO order. While out_valid & !out_ready, out_data and out_neg hold stable.
- Arithmetic (x = in_data):
  - Mode 00: {(OUT_W-IN_W){x[IN_W-1]}, x}.
  - Mode 01: {(OUT_W-IN_W){1'b0}, x}.
  - Mode 10: the mode-00 value shifted left by SHIFT, truncated to OUT_W bits, zeros shifted in.
  - Mode 11: {x, (OUT_W-IN_W){1'b0}}.
- Boundaries:
  - Full: both stages valid and out_ready = 0, so in_ready = 0 and in_valid is ignored.
  - Simultaneous accept and transfer when full with out_ready = 1: one beat leaves, the S1 beat moves to S2, and a new beat enters S1 in the same cycle.
  - Reset mid-operation discards all in-flight beats; no output follows reset until a new beat is accepted.

Optional Feature:
- Macro: IMM_EXTEND_PIPE_STATS_EN.
- When defined, add output port beat_cnt (16 bits).
  - Reset to 0 asynchronously.
  - Increments on every output transfer and saturates at 0xFFFF.
  - Add output port sat_seen (1 bit), set sticky when a mode-10 result's shift discards bits that differ from the result sign. Cleared only by reset.
- When undefined, neither port nor logic exists, and all other behaviour is identical.

Test Plan:
- Default params, out_ready=1, beat 0x7FF mode 00 -> out_valid 2 cycles later, out_data=0x000007FF, out_neg=0; beat 0x800 mode 00 -> 0xFFFFF800, out_neg=1.
- Modes on 0x800/0xFFF/0xABC: mode 01 0x800 -> 0x00000800; mode 10 0xFFF -> 0xFFFFFFFC; mode 11 0xABC -> 0xABC00000.
- Back-pressure: out_ready=0, offer beats 0x001,0x002,0x003 mode 01 back-to-back -> only 2 accepted, in_ready=0 on the third; out_data holds 0x00000001. Raise out_ready -> outputs 1,2 in order, then 0x003 is accepted; no loss or duplication.
- Streaming: 8 consecutive beats, out_ready=1 -> in_ready never drops; 8 results on 8 consecutive cycles after a 2-cycle latency.
- Reset mid-flight: 2 beats in the pipe, pulse rst_n low asynchronously between edges -> out_valid=0 and out_data=0 immediately, in_ready=0 during reset; no stale beats appear afterwards.
- With IMM_EXTEND_PIPE_STATS_EN: 5 transfers -> beat_cnt=5; mode 10 with IN_W=12, OUT_W=13, SHIFT=2, in 0x400 -> sat_seen=1.
